// File: rtl/pcm_segment_buffer.sv
// PCM output buffer: collects channel-sequential granules from synthesis into a ring of
// segments and plays them out as channel-interleaved frames once the ring is primed.
module pcm_segment_buffer #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 2,
    parameter int GRANULE      = 32,
    parameter int SEG_FRAMES   = 256,
    parameter int NUM_SEGS     = 2,
    parameter int PRIME_SEGS   = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               Flush_I,
    input  logic                               Mono_I,
    input  logic [DATA_WIDTH-1:0]              Wr_Data_I,
    input  logic                               Wr_En_I,
    output logic                               Full_O,
    output logic                               Overflow_O,
    input  logic                               Rd_En_I,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] Rd_Data_O,
    output logic                               Rd_Valid_O,
    output logic                               Empty_O,
    output logic                               Primed_O,
    output logic [15:0]                        Underrun_Count_O
);

    localparam int GPS   = SEG_FRAMES / GRANULE;
    localparam int DEPTH = NUM_SEGS * SEG_FRAMES;
    localparam int AW    = $clog2(DEPTH);
    localparam int SW    = (GRANULE > 1) ? $clog2(GRANULE) : 1;
    localparam int CW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int GW    = (GPS > 1) ? $clog2(GPS) : 1;
    localparam int SGW   = $clog2(NUM_SEGS);
    localparam int FW    = (SEG_FRAMES > 1) ? $clog2(SEG_FRAMES) : 1;
    localparam int NW    = $clog2(NUM_SEGS + 1);

    localparam logic [SW-1:0]  S_LAST   = SW'(GRANULE - 1);
    localparam logic [CW-1:0]  C_LAST   = CW'(NUM_CHANNELS - 1);
    localparam logic [GW-1:0]  G_LAST   = GW'(GPS - 1);
    localparam logic [SGW-1:0] SEG_LAST = SGW'(NUM_SEGS - 1);
    localparam logic [FW-1:0]  F_LAST   = FW'(SEG_FRAMES - 1);
    localparam logic [NW-1:0]  N_FULL   = NW'(NUM_SEGS);
    localparam logic [NW-1:0]  N_PRIME  = NW'(PRIME_SEGS);

    typedef enum logic {ST_UNPRIMED, ST_PRIMED} state_t;
    state_t state_q, state_d;

    logic [SW-1:0]  s_idx;
    logic [CW-1:0]  ch_idx;
    logic [GW-1:0]  g_idx;
    logic [SGW-1:0] wr_seg;
    logic [SGW-1:0] rd_seg;
    logic [FW-1:0]  rd_frame;
    logic [NW-1:0]  fill_cnt;
    logic           mono_q;
    logic           rd_valid_q;
    logic           rd_hit_q;

    logic           at_granule_start, mono_eff, wr_acc, rd_req, rd_hit, rd_under;
    logic           s_wrap, ch_wrap, g_wrap, seg_close, seg_free, rd_last;
    logic [CW-1:0]  ch_cur;
    logic [AW-1:0]  wr_addr, rd_addr;
    logic [DATA_WIDTH-1:0] ram_q [NUM_CHANNELS];

    // Mono is sampled live on the first write of a granule and held for the rest of it;
    // a mono granule pins ch_idx to the last lane so it closes after GRANULE writes.
    always_comb begin
        at_granule_start = (s_idx == '0) && (ch_idx == '0);
        mono_eff   = at_granule_start ? Mono_I : mono_q;
        ch_cur     = mono_eff ? C_LAST : ch_idx;
        wr_acc     = Wr_En_I && !Full_O && !Flush_I;
        s_wrap     = (s_idx == S_LAST);
        ch_wrap    = (ch_cur == C_LAST);
        g_wrap     = (g_idx == G_LAST);
        seg_close  = wr_acc && s_wrap && ch_wrap && g_wrap;
        rd_req     = Rd_En_I && !Flush_I;
        rd_hit     = rd_req && Primed_O && (fill_cnt != '0);
        rd_under   = rd_req && Primed_O && (fill_cnt == '0);
        rd_last    = (rd_frame == F_LAST);
        seg_free   = rd_hit && rd_last;
        wr_addr    = AW'(wr_seg) * AW'(SEG_FRAMES) + AW'(g_idx) * AW'(GRANULE) + AW'(s_idx);
        rd_addr    = AW'(rd_seg) * AW'(SEG_FRAMES) + AW'(rd_frame);
    end

    always_ff @(posedge clock) begin
        if (reset || Flush_I) begin
            s_idx      <= '0;
            ch_idx     <= '0;
            g_idx      <= '0;
            wr_seg     <= '0;
            rd_seg     <= '0;
            rd_frame   <= '0;
            fill_cnt   <= '0;
            mono_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_req;
            rd_hit_q   <= rd_hit;
            if (at_granule_start)
                mono_q <= Mono_I;
            if (wr_acc) begin
                s_idx <= s_wrap ? '0 : s_idx + 1'b1;
                if (s_wrap)
                    ch_idx <= ch_wrap ? '0 : ch_cur + 1'b1;
                else
                    ch_idx <= ch_cur;
                if (s_wrap && ch_wrap) begin
                    g_idx <= g_wrap ? '0 : g_idx + 1'b1;
                    if (g_wrap)
                        wr_seg <= (wr_seg == SEG_LAST) ? '0 : wr_seg + 1'b1;
                end
            end
            if (rd_hit) begin
                rd_frame <= rd_last ? '0 : rd_frame + 1'b1;
                if (rd_last)
                    rd_seg <= (rd_seg == SEG_LAST) ? '0 : rd_seg + 1'b1;
            end
            case ({seg_close, seg_free})
                2'b10:   fill_cnt <= fill_cnt + 1'b1;
                2'b01:   fill_cnt <= fill_cnt - 1'b1;
                default: fill_cnt <= fill_cnt;
            endcase
        end
    end

    // Sticky status survives Flush_I; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            Overflow_O       <= 1'b0;
            Underrun_Count_O <= '0;
        end else begin
            if (Wr_En_I && Full_O && !Flush_I)
                Overflow_O <= 1'b1;
            if (rd_under && (Underrun_Count_O != '1))
                Underrun_Count_O <= Underrun_Count_O + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || Flush_I)
            state_q <= ST_UNPRIMED;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_UNPRIMED: if (fill_cnt >= N_PRIME) state_d = ST_PRIMED;
            ST_PRIMED:   state_d = ST_PRIMED;
            default:     state_d = ST_UNPRIMED;
        endcase
    end

    always_comb begin
        Primed_O   = (state_q == ST_PRIMED);
        Full_O     = (fill_cnt == N_FULL);
        Empty_O    = (fill_cnt == '0);
        Rd_Valid_O = rd_valid_q;
        Rd_Data_O  = '0;
        for (int unsigned l = 0; l < NUM_CHANNELS; l++)
            Rd_Data_O[l*DATA_WIDTH +: DATA_WIDTH] = rd_hit_q ? ram_q[l] : '0;
    end

    for (genvar l = 0; l < NUM_CHANNELS; l++) begin : g_lane
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        always_ff @(posedge clock) begin
            if (wr_acc && (mono_eff || (ch_idx == CW'(l))))
                mem[wr_addr] <= Wr_Data_I;
            ram_q[l] <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_pcm_segment_buffer.sv
// Scoreboard bench for pcm_segment_buffer: default 2-channel instance plus a 4-channel,
// 3-segment instance; read frames are predicted by a behavioural model of the buffer.
module tb_pcm_segment_buffer;

    localparam int DW = 16, NCH = 2, G = 32, SEG = 256, NSEG = 2, PRIME = 2;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1, flush = 1'b0, mono = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        full, overflow, rd_valid, empty, primed;
    logic [31:0] rd_data;
    logic [15:0] underrun;

    logic        c4_flush = 1'b0, c4_mono = 1'b0, c4_wr_en = 1'b0, c4_rd_en = 1'b0;
    logic [15:0] c4_wr_data = '0;
    logic        c4_full, c4_overflow, c4_rd_valid, c4_empty, c4_primed;
    logic [63:0] c4_rd_data;
    logic [15:0] c4_underrun;

    pcm_segment_buffer u_dut (
        .clock(clock), .reset(reset), .Flush_I(flush), .Mono_I(mono),
        .Wr_Data_I(wr_data), .Wr_En_I(wr_en), .Full_O(full), .Overflow_O(overflow),
        .Rd_En_I(rd_en), .Rd_Data_O(rd_data), .Rd_Valid_O(rd_valid), .Empty_O(empty),
        .Primed_O(primed), .Underrun_Count_O(underrun)
    );

    pcm_segment_buffer #(
        .DATA_WIDTH(16), .NUM_CHANNELS(4), .GRANULE(32),
        .SEG_FRAMES(64), .NUM_SEGS(3), .PRIME_SEGS(1)
    ) u_dut4 (
        .clock(clock), .reset(reset), .Flush_I(c4_flush), .Mono_I(c4_mono),
        .Wr_Data_I(c4_wr_data), .Wr_En_I(c4_wr_en), .Full_O(c4_full), .Overflow_O(c4_overflow),
        .Rd_En_I(c4_rd_en), .Rd_Data_O(c4_rd_data), .Rd_Valid_O(c4_rd_valid), .Empty_O(c4_empty),
        .Primed_O(c4_primed), .Underrun_Count_O(c4_underrun)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [63:0] q4[$];

    // behavioural model of the default instance
    int          m_fill = 0, m_s = 0, m_ch = 0, m_g = 0, m_rdf = 0, m_und = 0;
    bit          m_primed = 0, m_mono = 0, m_ovf = 0;
    logic [31:0] m_build [SEG];
    logic [31:0] m_frames[$];

    always @(negedge clock) begin : mon
        logic [31:0] e;
        if (rd_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected got=%h expected=none", rd_data);
            end else begin
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data got=%h expected=%h", rd_data, e);
                end
            end
        end
    end

    always @(negedge clock) begin : mon4
        logic [63:0] e;
        if (c4_rd_valid === 1'b1) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL c4_rd_unexpected got=%h expected=none", c4_rd_data);
            end else begin
                e = q4.pop_front();
                if (c4_rd_data !== e) begin
                    errors++;
                    $display("FAIL c4_rd_data got=%h expected=%h", c4_rd_data, e);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] val(input int tag, input int ch, input int f);
        logic [15:0] v;
        v = {tag[3:0], ch[3:0], f[7:0]};
        return v;
    endfunction

    // one clock of the default instance; the model is updated from pre-edge state
    task automatic cycle(input bit wr, input logic [15:0] d, input bit mo, input bit rd, input bit fl);
        int inc, dec, f, ch_cur;
        bit meff;
        inc = 0;
        dec = 0;
        if (fl) begin
            m_frames.delete();
            m_fill = 0; m_s = 0; m_ch = 0; m_g = 0; m_rdf = 0;
            m_primed = 0; m_mono = 0;
        end else begin
            if (rd) begin
                if (!m_primed) exp_q.push_back('0);
                else if (m_fill == 0) begin
                    exp_q.push_back('0);
                    if (m_und < 65535) m_und++;
                end else begin
                    exp_q.push_back(m_frames.pop_front());
                    m_rdf++;
                    if (m_rdf == SEG) begin m_rdf = 0; dec = 1; end
                end
            end
            if (wr) begin
                if (m_fill == NSEG) m_ovf = 1;
                else begin
                    meff = (m_s == 0 && m_ch == 0) ? mo : m_mono;
                    if (m_s == 0 && m_ch == 0) m_mono = mo;
                    f = m_g * G + m_s;
                    if (meff) begin
                        for (int c = 0; c < NCH; c++) m_build[f][c*16 +: 16] = d;
                        ch_cur = NCH - 1;
                    end else begin
                        m_build[f][m_ch*16 +: 16] = d;
                        ch_cur = m_ch;
                    end
                    m_s++;
                    if (m_s == G) begin
                        m_s = 0;
                        if (ch_cur == NCH - 1) begin
                            m_ch = 0;
                            m_g++;
                            if (m_g == SEG / G) begin
                                m_g = 0;
                                for (int i = 0; i < SEG; i++) m_frames.push_back(m_build[i]);
                                inc = 1;
                            end
                        end else m_ch = ch_cur + 1;
                    end else m_ch = ch_cur;
                end
            end
            m_fill = m_fill + inc - dec;
            if (m_fill >= PRIME) m_primed = 1;
        end
        wr_en = wr; wr_data = d; mono = mo; rd_en = rd; flush = fl;
        @(posedge clock);
        #1;
        wr_en = 0; rd_en = 0; flush = 0; mono = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, '0, 0, 0, 0);
    endtask

    task automatic write_seg(input int tag, input int count);
        int k;
        k = 0;
        for (int g = 0; g < SEG / G; g++)
            for (int c = 0; c < NCH; c++)
                for (int s = 0; s < G; s++) begin
                    if (k < count) cycle(1, val(tag, c, g * G + s), 0, 0, 0);
                    k++;
                end
    endtask

    task automatic read_n(input int n);
        repeat (n) cycle(0, '0, 0, 1, 0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        checks += 7;
        if (full !== 1'b0)      begin errors++; $display("FAIL reset_full got=%b expected=0", full); end
        if (empty !== 1'b1)     begin errors++; $display("FAIL reset_empty got=%b expected=1", empty); end
        if (primed !== 1'b0)    begin errors++; $display("FAIL reset_primed got=%b expected=0", primed); end
        if (rd_valid !== 1'b0)  begin errors++; $display("FAIL reset_rd_valid got=%b expected=0", rd_valid); end
        if (rd_data !== '0)     begin errors++; $display("FAIL reset_rd_data got=%h expected=0", rd_data); end
        if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow got=%b expected=0", overflow); end
        if (underrun !== '0)    begin errors++; $display("FAIL reset_underrun got=%h expected=0", underrun); end
    endtask

    task automatic test_ramp;
        read_n(1);
        write_seg(0, SEG * NCH);
        idle(2);
        checks += 2;
        if (primed !== 1'b0) begin errors++; $display("FAIL ramp_primed_one_seg got=%b expected=0", primed); end
        if (empty !== 1'b0)  begin errors++; $display("FAIL ramp_empty_one_seg got=%b expected=0", empty); end
        write_seg(1, SEG * NCH);
        idle(2);
        checks += 2;
        if (primed !== 1'b1) begin errors++; $display("FAIL ramp_primed got=%b expected=1", primed); end
        if (full !== 1'b1)   begin errors++; $display("FAIL ramp_full got=%b expected=1", full); end
    endtask

    task automatic test_full;
        cycle(1, 16'hDEAD, 0, 0, 0);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow got=%b expected=1", overflow); end
        for (int i = 0; i < SEG; i++) begin
            cycle(0, '0, 0, 1, 0);
            if (i == 0) begin
                checks++;
                if (rd_data !== 32'h0100_0000) begin errors++; $display("FAIL first_frame got=%h expected=01000000", rd_data); end
            end
            if (i == SEG - 1) begin
                checks++;
                if (rd_data !== 32'h01FF_00FF) begin errors++; $display("FAIL last_frame got=%h expected=01ff00ff", rd_data); end
            end
        end
        checks += 2;
        if (full !== 1'b0)  begin errors++; $display("FAIL full_after_read got=%b expected=0", full); end
        if (empty !== 1'b0) begin errors++; $display("FAIL empty_after_read got=%b expected=0", empty); end
        write_seg(2, SEG * NCH);
        idle(2);
        checks += 2;
        if (full !== 1'b1)     begin errors++; $display("FAIL full_refill got=%b expected=1", full); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got=%b expected=1", overflow); end
    endtask

    task automatic test_underrun;
        read_n(2 * SEG);
        idle(1);
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL underrun_empty got=%b expected=1", empty); end
        read_n(3);
        checks += 2;
        if (underrun !== 16'd3) begin errors++; $display("FAIL underrun_count got=%0d expected=3", underrun); end
        if (underrun !== 16'(m_und)) begin errors++; $display("FAIL underrun_model got=%0d expected=%0d", underrun, m_und); end
        idle(2);
    endtask

    task automatic test_concurrent;
        write_seg(3, SEG * NCH);
        write_seg(4, SEG * NCH - 1);
        read_n(SEG - 1);
        cycle(1, val(4, 1, SEG - 1), 0, 1, 0);
        checks += 2;
        if (empty !== 1'b0) begin errors++; $display("FAIL concurrent_empty got=%b expected=0", empty); end
        if (full !== 1'b0)  begin errors++; $display("FAIL concurrent_full got=%b expected=0", full); end
        read_n(SEG);
        idle(2);
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL concurrent_drain_empty got=%b expected=1", empty); end
    endtask

    task automatic test_mono;
        for (int s = 0; s < G; s++) cycle(1, 16'h1234, 1, 0, 0);
        // mono raised mid-granule must be ignored
        for (int g = 1; g < SEG / G; g++)
            for (int c = 0; c < NCH; c++)
                for (int s = 0; s < G; s++)
                    cycle(1, val(5, c, g * G + s), (g == 1) && !(c == 0 && s < 5), 0, 0);
        idle(2);
        cycle(0, '0, 0, 1, 0);
        checks++;
        if (rd_data !== 32'h1234_1234) begin errors++; $display("FAIL mono_frame0 got=%h expected=12341234", rd_data); end
        read_n(SEG - 1);
        idle(2);
    endtask

    task automatic test_flush;
        write_seg(6, 40);
        cycle(1, 16'hBEEF, 0, 1, 1);
        checks += 5;
        if (empty !== 1'b1)     begin errors++; $display("FAIL flush_empty got=%b expected=1", empty); end
        if (primed !== 1'b0)    begin errors++; $display("FAIL flush_primed got=%b expected=0", primed); end
        if (rd_valid !== 1'b0)  begin errors++; $display("FAIL flush_rd_valid got=%b expected=0", rd_valid); end
        if (overflow !== 1'b1)  begin errors++; $display("FAIL flush_overflow got=%b expected=1", overflow); end
        if (underrun !== 16'd3) begin errors++; $display("FAIL flush_underrun got=%0d expected=3", underrun); end
        read_n(1);
        write_seg(7, SEG * NCH);
        idle(2);
        checks += 2;
        if (primed !== 1'b0)    begin errors++; $display("FAIL reprime_early got=%b expected=0", primed); end
        if (underrun !== 16'd3) begin errors++; $display("FAIL unprimed_read_count got=%0d expected=3", underrun); end
        write_seg(8, SEG * NCH);
        idle(2);
        checks++;
        if (primed !== 1'b1) begin errors++; $display("FAIL reprime got=%b expected=1", primed); end
        read_n(2 * SEG);
        idle(2);
    endtask

    task automatic test_quad;
        for (int g = 0; g < 2; g++)
            for (int c = 0; c < 4; c++)
                for (int s = 0; s < G; s++) begin
                    c4_wr_en = 1'b1;
                    c4_wr_data = val(0, c, g * G + s);
                    @(posedge clock);
                    #1;
                end
        c4_wr_en = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks += 3;
        if (c4_primed !== 1'b1) begin errors++; $display("FAIL c4_primed got=%b expected=1", c4_primed); end
        if (c4_empty !== 1'b0)  begin errors++; $display("FAIL c4_empty got=%b expected=0", c4_empty); end
        if (c4_full !== 1'b0)   begin errors++; $display("FAIL c4_full got=%b expected=0", c4_full); end
        for (int f = 0; f < 64; f++) begin
            q4.push_back({val(0, 3, f), val(0, 2, f), val(0, 1, f), val(0, 0, f)});
            c4_rd_en = 1'b1;
            @(posedge clock);
            #1;
            if (f == 0) begin
                checks++;
                if (c4_rd_data[63:48] !== 16'h0300) begin errors++; $display("FAIL c4_lane3 got=%h expected=0300", c4_rd_data[63:48]); end
            end
        end
        c4_rd_en = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (c4_empty !== 1'b1) begin errors++; $display("FAIL c4_drain_empty got=%b expected=1", c4_empty); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_full();
        test_underrun();
        test_concurrent();
        test_mono();
        test_flush();
        test_quad();
        idle(3);
        checks += 2;
        if (exp_q.size() != 0) begin errors++; $display("FAIL pending_reads got=%0d expected=0", exp_q.size()); end
        if (q4.size() != 0)    begin errors++; $display("FAIL c4_pending_reads got=%0d expected=0", q4.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
